// File: rtl/eco32f_lsu.sv
// eco32f_lsu: MEM-stage load/store unit with a wait-state data bus and writeback.
module eco32f_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_load,
   input  logic        mem_store,
   input  logic [1:0]  mem_size,
   input  logic        mem_signed,
   input  logic        mem_flush,
   input  logic [4:0]  mem_rf_r_addr,
   input  logic        mem_rf_r_we,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_store_data,
   output logic        mem_stall,
   output logic        mem_except_align,
   output logic        mem_except_bus,
   output logic [31:0] dbus_adr,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [3:0]  dbus_sel,
   output logic [31:0] dbus_dat_o,
   input  logic [31:0] dbus_dat_i,
   input  logic        dbus_ack,
   input  logic        dbus_err,
   output logic [4:0]  wb_rf_r_addr,
   output logic        wb_rf_r_we,
   output logic [31:0] wb_rf_r
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state, state_nx;
   logic mem_op, aligned, kill;
   logic [1:0] off;
   logic [3:0] sel_nx;
   logic [31:0] dat_nx, byte_sh, lane, ext, ld_data;
   assign off     = mem_alu_result[1:0];
   assign mem_op  = (mem_load | mem_store) & !mem_flush;
   assign aligned = mem_size == 2'd0 ? 1'b1 : mem_size == 2'd1 ? !off[0] : off == 2'd0;
   assign sel_nx  = mem_size == 2'd0 ? 4'b1000 >> off :
                    mem_size == 2'd1 ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
   assign dat_nx  = mem_size == 2'd0 ? {4{mem_store_data[7:0]}} :
                    mem_size == 2'd1 ? {2{mem_store_data[15:0]}} : mem_store_data;
   // big-endian: byte at offset k lives in bits 8*(3-k)+7 : 8*(3-k)
   assign byte_sh = dbus_dat_i >> {~off, 3'b000};
   assign lane    = mem_size == 2'd0 ? {24'h0, byte_sh[7:0]} :
                    mem_size == 2'd1 ? {16'h0, off[1] ? dbus_dat_i[15:0] : dbus_dat_i[31:16]} : dbus_dat_i;
   assign ext     = mem_size == 2'd0 ? {{24{mem_signed & ld_data[7]}}, ld_data[7:0]} :
                    mem_size == 2'd1 ? {{16{mem_signed & ld_data[15]}}, ld_data[15:0]} : ld_data;
   assign mem_stall = state == ACCESS | (state == IDLE & mem_op & aligned);
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = mem_op & aligned ? ACCESS : IDLE;
         ACCESS:  state_nx = dbus_err ? IDLE : dbus_ack ? DONE : ACCESS;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         dbus_req         <= 1'b0;
         dbus_we          <= 1'b0;
         dbus_sel         <= 4'b0;
         wb_rf_r_we       <= 1'b0;
         mem_except_align <= 1'b0;
         mem_except_bus   <= 1'b0;
         kill             <= 1'b0;
      end else begin
         state            <= state_nx;
         mem_except_align <= 1'b0;
         mem_except_bus   <= 1'b0;
         case (state)
            IDLE: begin
               kill <= 1'b0;
               if (mem_op & !aligned) begin
                  mem_except_align <= 1'b1;
                  wb_rf_r_we       <= 1'b0;
               end else if (mem_op) begin
                  dbus_req   <= 1'b1;
                  dbus_we    <= mem_store;
                  dbus_sel   <= sel_nx;
                  wb_rf_r_we <= 1'b0;
               end else
                  wb_rf_r_we <= mem_rf_r_we & !mem_flush;
            end
            ACCESS: begin
               wb_rf_r_we <= 1'b0;
               if (mem_flush) kill <= 1'b1;
               if (dbus_err | dbus_ack) dbus_req <= 1'b0;
               if (dbus_err) begin
                  mem_except_bus <= !(kill | mem_flush);
                  kill           <= 1'b0;
               end
            end
            default: begin
               wb_rf_r_we <= !dbus_we & mem_rf_r_we & !kill;
               kill       <= 1'b0;
            end
         endcase
      end
   end
   // address/data registers carry no reset value
   always_ff @(posedge clk) begin
      wb_rf_r_addr <= mem_rf_r_addr;
      if (state == IDLE & !mem_op) wb_rf_r <= mem_alu_result;
      if (state == IDLE & mem_op & aligned) begin
         dbus_adr   <= {mem_alu_result[31:2], 2'b00};
         dbus_dat_o <= dat_nx;
      end
      if (state == ACCESS & dbus_ack & !dbus_err) ld_data <= lane;
      if (state == DONE & !dbus_we) wb_rf_r <= ext;
   end
endmodule

// File: tb/tb_eco32f_lsu.sv
// tb_eco32f_lsu: directed tests for the eco32f load/store unit.
module tb_eco32f_lsu;
   logic        clk = 1'b0, rst = 1'b0;
   logic        mem_load, mem_store, mem_signed, mem_flush, mem_rf_r_we;
   logic [1:0]  mem_size;
   logic [4:0]  mem_rf_r_addr;
   logic [31:0] mem_alu_result, mem_store_data, dbus_dat_i;
   logic        dbus_ack, dbus_err;
   logic        mem_stall, mem_except_align, mem_except_bus, dbus_req, dbus_we, wb_rf_r_we;
   logic [31:0] dbus_adr, dbus_dat_o, wb_rf_r;
   logic [3:0]  dbus_sel;
   logic [4:0]  wb_rf_r_addr;
   int tests = 0, fails = 0;

   eco32f_lsu dut (
      .clk(clk), .rst(rst), .mem_load(mem_load), .mem_store(mem_store), .mem_size(mem_size),
      .mem_signed(mem_signed), .mem_flush(mem_flush), .mem_rf_r_addr(mem_rf_r_addr),
      .mem_rf_r_we(mem_rf_r_we), .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
      .mem_stall(mem_stall), .mem_except_align(mem_except_align), .mem_except_bus(mem_except_bus),
      .dbus_adr(dbus_adr), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_sel(dbus_sel),
      .dbus_dat_o(dbus_dat_o), .dbus_dat_i(dbus_dat_i), .dbus_ack(dbus_ack), .dbus_err(dbus_err),
      .wb_rf_r_addr(wb_rf_r_addr), .wb_rf_r_we(wb_rf_r_we), .wb_rf_r(wb_rf_r)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      mem_load = 0; mem_store = 0; mem_size = 0; mem_signed = 0; mem_flush = 0;
      mem_rf_r_addr = 0; mem_rf_r_we = 0; mem_alu_result = 0; mem_store_data = 0;
      dbus_dat_i = 0; dbus_ack = 0; dbus_err = 0;
   endtask

   task automatic set_op(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] adr, input logic [31:0] sd, input logic [4:0] rd, input logic we);
      mem_load = ld; mem_store = st; mem_size = sz; mem_signed = sg; mem_flush = 0;
      mem_alu_result = adr; mem_store_data = sd; mem_rf_r_addr = rd; mem_rf_r_we = we;
   endtask

   task automatic test_reset();
      idle_inputs();
      #3;
      tests++; if ({dbus_req, dbus_we, dbus_sel, wb_rf_r_we, mem_except_align, mem_except_bus, mem_stall} !== 10'b0) begin
         fails++; $display("FAIL reset_outputs got=%b exp=0", {dbus_req, dbus_we, dbus_sel, wb_rf_r_we, mem_except_align, mem_except_bus, mem_stall});
      end
      @(negedge clk); rst = 1;
      @(negedge clk);
   endtask

   task automatic test_alu();
      set_op(0, 0, 2, 0, 32'h12345678, 0, 5, 1);
      #1;
      tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL alu_stall got=%b exp=0", mem_stall); end
      @(negedge clk);
      tests++; if ({wb_rf_r_addr, wb_rf_r_we, wb_rf_r} !== {5'd5, 1'b1, 32'h12345678}) begin
         fails++; $display("FAIL alu_wb got=%0d/%b/%h exp=5/1/12345678", wb_rf_r_addr, wb_rf_r_we, wb_rf_r);
      end
      idle_inputs();
      @(negedge clk);
      tests++; if (wb_rf_r_we !== 1'b0) begin fails++; $display("FAIL alu_bubble got=%b exp=0", wb_rf_r_we); end
   endtask

   task automatic test_load_byte();
      int stalls = 0;
      set_op(1, 0, 0, 1, 32'h00001001, 0, 7, 1);
      #1; if (mem_stall) stalls++;
      @(negedge clk);
      tests++; if ({dbus_req, dbus_we, dbus_sel, dbus_adr} !== {1'b1, 1'b0, 4'b0100, 32'h00001000}) begin
         fails++; $display("FAIL lb_bus got=%b/%b/%b/%h exp=1/0/0100/00001000", dbus_req, dbus_we, dbus_sel, dbus_adr);
      end
      if (mem_stall) stalls++;
      @(negedge clk); if (mem_stall) stalls++;
      @(negedge clk); if (mem_stall) stalls++;
      dbus_ack = 1; dbus_dat_i = 32'h11F23344;
      @(negedge clk);
      dbus_ack = 0;
      if (mem_stall) stalls++;
      tests++; if ({dbus_req, wb_rf_r_we} !== 2'b00) begin
         fails++; $display("FAIL lb_done got=%b exp=00", {dbus_req, wb_rf_r_we});
      end
      tests++; if (stalls !== 4) begin fails++; $display("FAIL lb_stall_cycles got=%0d exp=4", stalls); end
      @(negedge clk);
      tests++; if ({wb_rf_r_addr, wb_rf_r_we, wb_rf_r} !== {5'd7, 1'b1, 32'hFFFFFFF2}) begin
         fails++; $display("FAIL lb_wb got=%0d/%b/%h exp=7/1/fffffff2", wb_rf_r_addr, wb_rf_r_we, wb_rf_r);
      end
      idle_inputs();
   endtask

   task automatic test_store_half();
      set_op(0, 1, 1, 0, 32'h00002002, 32'h0000ABCD, 4, 1);
      @(negedge clk);
      tests++; if ({dbus_req, dbus_we, dbus_sel, dbus_adr, dbus_dat_o} !== {1'b1, 1'b1, 4'b0011, 32'h00002000, 32'hABCDABCD}) begin
         fails++; $display("FAIL sh_bus got=%b/%b/%b/%h/%h exp=1/1/0011/00002000/abcdabcd", dbus_req, dbus_we, dbus_sel, dbus_adr, dbus_dat_o);
      end
      dbus_ack = 1;
      @(negedge clk);
      dbus_ack = 0;
      tests++; if ({dbus_req, mem_stall} !== 2'b00) begin fails++; $display("FAIL sh_done got=%b exp=00", {dbus_req, mem_stall}); end
      @(negedge clk);
      tests++; if (wb_rf_r_we !== 1'b0) begin fails++; $display("FAIL sh_no_wb got=%b exp=0", wb_rf_r_we); end
      idle_inputs();
   endtask

   task automatic test_align();
      set_op(1, 0, 2, 0, 32'h00003001, 0, 6, 1);
      #1;
      tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL align_stall got=%b exp=0", mem_stall); end
      @(negedge clk);
      tests++; if ({mem_except_align, dbus_req, wb_rf_r_we} !== 3'b100) begin
         fails++; $display("FAIL align_pulse got=%b exp=100", {mem_except_align, dbus_req, wb_rf_r_we});
      end
      idle_inputs();
      @(negedge clk);
      tests++; if (mem_except_align !== 1'b0) begin fails++; $display("FAIL align_one_cycle got=%b exp=0", mem_except_align); end
   endtask

   task automatic test_bus_err(input logic flush);
      set_op(1, 0, 2, 0, 32'h00004000, 0, 8, 1);
      @(negedge clk);
      mem_flush = flush;
      @(negedge clk);
      mem_flush = 0;
      @(negedge clk);
      dbus_err = 1;
      @(negedge clk);
      idle_inputs();
      tests++; if ({mem_except_bus, dbus_req, wb_rf_r_we} !== {~flush, 2'b00}) begin
         fails++; $display("FAIL bus_err_f%0d got=%b exp=%b", flush, {mem_except_bus, dbus_req, wb_rf_r_we}, {~flush, 2'b00});
      end
      @(negedge clk);
      tests++; if ({mem_except_bus, wb_rf_r_we} !== 2'b00) begin
         fails++; $display("FAIL bus_err_after_f%0d got=%b exp=00", flush, {mem_except_bus, wb_rf_r_we});
      end
   endtask

   task automatic test_flush_ack();
      set_op(1, 0, 2, 0, 32'h00004100, 0, 9, 1);
      @(negedge clk);
      mem_flush = 1;
      @(negedge clk);
      mem_flush = 0; dbus_ack = 1; dbus_dat_i = 32'h55555555;
      @(negedge clk);
      dbus_ack = 0;
      @(negedge clk);
      tests++; if (wb_rf_r_we !== 1'b0) begin fails++; $display("FAIL flush_ack_wb got=%b exp=0", wb_rf_r_we); end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      set_op(1, 0, 2, 0, 32'h00005000, 0, 10, 1);
      @(negedge clk);
      tests++; if (dbus_req !== 1'b1) begin fails++; $display("FAIL rst_pre_req got=%b exp=1", dbus_req); end
      #2 rst = 0;
      #1;
      tests++; if ({dbus_req, wb_rf_r_we} !== 2'b00) begin
         fails++; $display("FAIL rst_async got=%b exp=00", {dbus_req, wb_rf_r_we});
      end
      idle_inputs();
      @(negedge clk); rst = 1;
      set_op(0, 0, 2, 0, 32'hCAFEF00D, 0, 9, 1);
      #1;
      tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL rst_post_stall got=%b exp=0", mem_stall); end
      @(negedge clk);
      tests++; if ({wb_rf_r_addr, wb_rf_r_we, wb_rf_r} !== {5'd9, 1'b1, 32'hCAFEF00D}) begin
         fails++; $display("FAIL rst_post_alu got=%0d/%b/%h exp=9/1/cafef00d", wb_rf_r_addr, wb_rf_r_we, wb_rf_r);
      end
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      set_op(1, 0, 2, 0, 32'h00006000, 0, 3, 1);
      @(negedge clk);
      dbus_ack = 1; dbus_dat_i = 32'hDEADBEEF;
      @(negedge clk);
      dbus_ack = 0;
      tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL b2b_done_stall got=%b exp=0", mem_stall); end
      @(negedge clk);
      tests++; if ({wb_rf_r_addr, wb_rf_r_we, wb_rf_r} !== {5'd3, 1'b1, 32'hDEADBEEF}) begin
         fails++; $display("FAIL b2b_lw got=%0d/%b/%h exp=3/1/deadbeef", wb_rf_r_addr, wb_rf_r_we, wb_rf_r);
      end
      set_op(0, 1, 0, 0, 32'h00006003, 32'h1234565A, 0, 0);
      #1;
      tests++; if (mem_stall !== 1'b1) begin fails++; $display("FAIL b2b_sb_stall got=%b exp=1", mem_stall); end
      @(negedge clk);
      tests++; if ({dbus_req, dbus_we, dbus_sel, dbus_dat_o} !== {1'b1, 1'b1, 4'b0001, 32'h5A5A5A5A}) begin
         fails++; $display("FAIL b2b_sb_bus got=%b/%b/%b/%h exp=1/1/0001/5a5a5a5a", dbus_req, dbus_we, dbus_sel, dbus_dat_o);
      end
      dbus_ack = 1;
      @(negedge clk);
      dbus_ack = 0;
      @(negedge clk);
      tests++; if (wb_rf_r_we !== 1'b0) begin fails++; $display("FAIL b2b_sb_wb got=%b exp=0", wb_rf_r_we); end
      set_op(1, 0, 1, 0, 32'h00006002, 0, 12, 1);
      @(negedge clk);
      tests++; if ({dbus_sel, dbus_we} !== {4'b0011, 1'b0}) begin
         fails++; $display("FAIL b2b_lhu_bus got=%b/%b exp=0011/0", dbus_sel, dbus_we);
      end
      dbus_ack = 1; dbus_dat_i = 32'h12348765;
      @(negedge clk);
      dbus_ack = 0;
      @(negedge clk);
      tests++; if ({wb_rf_r_addr, wb_rf_r_we, wb_rf_r} !== {5'd12, 1'b1, 32'h00008765}) begin
         fails++; $display("FAIL b2b_lhu got=%0d/%b/%h exp=12/1/00008765", wb_rf_r_addr, wb_rf_r_we, wb_rf_r);
      end
      idle_inputs();
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_byte();
      test_store_half();
      test_align();
      test_bus_err(1'b0);
      test_bus_err(1'b1);
      test_flush_ack();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
